// File: rtl/dac_serial_driver.sv
// rtl/dac_serial_driver.sv - three-wire DAC serial driver (CLK/SDI/LD/CLR), MSB-first with programmable bit divider.
// Optional continuous refresh of the last sample when DAC_AUTO_REPEAT_EN is defined.
module dac_serial_driver #(
  parameter int DATA_W   = 12,
  parameter int DIV      = 4,
  parameter int LD_SETUP = 2,
  parameter int LD_LOW   = 2,
  parameter int GAP      = 2,
  parameter int CLR_LOW  = 2
) (
  input  logic              clk_X4,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              clr_req,
  output logic              busy,
  output logic              frame_done,
  output logic              CLK_3,
  output logic              SDI_4,
  output logic              LD_5,
  output logic              CLR_6
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam int PH_W  = $clog2(DIV);
  localparam int M1    = (LD_SETUP > LD_LOW) ? LD_SETUP : LD_LOW;
  localparam int M2    = (GAP > CLR_LOW) ? GAP : CLR_LOW;
  localparam int WMAX  = (M1 > M2) ? M1 : M2;
  localparam int W_W   = $clog2(WMAX + 1);

  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);
  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(DIV - 1);
  localparam logic [PH_W-1:0]  PH_HALF    = PH_W'(DIV / 2);
  localparam logic [W_W-1:0]   SETUP_LAST = W_W'(LD_SETUP - 1);
  localparam logic [W_W-1:0]   LOW_LAST   = W_W'(LD_LOW - 1);
  localparam logic [W_W-1:0]   GAP_LAST   = W_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [W_W-1:0]   CLR_LAST   = W_W'(CLR_LOW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_LDSET,
    S_LOAD,
    S_GAP,
    S_CLEAR
  } state_t;

  state_t            state, state_n;
  logic [BIT_W-1:0]  bit_cnt, bit_n;
  logic [PH_W-1:0]   phase, phase_n;
  logic [W_W-1:0]    wait_cnt, wait_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              clk_n, sdi_n, ld_n, clr_n, busy_n, done_n;

`ifdef DAC_AUTO_REPEAT_EN
  logic [DATA_W-1:0] last_sample;
  logic              have_last;
`endif

  assign data_ready = (state == S_IDLE) && enable && !clr_req && !rst;

  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    phase_n = phase;
    wait_n  = wait_cnt;
    shreg_n = shreg;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (clr_req) begin
          state_n = S_CLEAR;
          wait_n  = '0;
        end else if (data_valid) begin
          state_n = S_SHIFT;
          shreg_n = data_in;
          bit_n   = BIT_LAST;
          phase_n = '0;
        end
`ifdef DAC_AUTO_REPEAT_EN
        else if (have_last) begin
          state_n = S_SHIFT;
          shreg_n = last_sample;
          bit_n   = BIT_LAST;
          phase_n = '0;
        end
`endif
      end
      S_SHIFT: begin
        if (phase == PH_LAST) begin
          phase_n = '0;
          if (bit_cnt == '0) begin
            state_n = S_LDSET;
            wait_n  = '0;
          end else begin
            bit_n   = bit_cnt - 1'b1;
            shreg_n = {shreg[DATA_W-2:0], 1'b0};
          end
        end else begin
          phase_n = phase + 1'b1;
        end
      end
      S_LDSET: begin
        if (wait_cnt == SETUP_LAST) begin
          state_n = S_LOAD;
          wait_n  = '0;
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end
      S_LOAD: begin
        if (wait_cnt == LOW_LAST) begin
          state_n = (GAP == 0) ? S_IDLE : S_GAP;
          wait_n  = '0;
          done_n  = 1'b1;
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (wait_cnt == GAP_LAST) begin
          state_n = S_IDLE;
          wait_n  = '0;
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end
      S_CLEAR: begin
        if (wait_cnt == CLR_LAST) begin
          state_n = S_IDLE;
          wait_n  = '0;
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Abort wins over everything: partial frame dropped, no LD pulse, no frame_done.
    if (!enable) begin
      state_n = S_IDLE;
      done_n  = 1'b0;
    end

    // Pins are registered from the next state so they line up with the state they describe.
    clk_n  = !((state_n == S_SHIFT) && (phase_n < PH_HALF));
    sdi_n  = (state_n == S_SHIFT) && shreg_n[DATA_W-1];
    ld_n   = (state_n != S_LOAD);
    clr_n  = (state_n != S_CLEAR);
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk_X4) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      phase      <= '0;
      wait_cnt   <= '0;
      shreg      <= '0;
      CLK_3      <= 1'b1;
      SDI_4      <= 1'b0;
      LD_5       <= 1'b1;
      CLR_6      <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_n;
      phase      <= phase_n;
      wait_cnt   <= wait_n;
      shreg      <= shreg_n;
      CLK_3      <= clk_n;
      SDI_4      <= sdi_n;
      LD_5       <= ld_n;
      CLR_6      <= clr_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

`ifdef DAC_AUTO_REPEAT_EN
  always_ff @(posedge clk_X4) begin
    if (rst) begin
      last_sample <= '0;
      have_last   <= 1'b0;
    end else if (data_ready && data_valid) begin
      last_sample <= data_in;
      have_last   <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_serial_driver.sv
// tb/tb_dac_serial_driver.sv - self-checking bench for dac_serial_driver (default and 16-bit/DIV=8 instances).
module tb_dac_serial_driver;

  localparam int LDS = 2;
  localparam int LDL = 2;
  localparam int GP  = 2;
  localparam int CLW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, data_valid, clr_req;
  logic [11:0] data_in;
  logic        data_ready, busy, frame_done, CLK_3, SDI_4, LD_5, CLR_6;

  logic [15:0] d2_data;
  logic        d2_valid, d2_ready, d2_busy, d2_done, d2_clk, d2_sdi, d2_ld, d2_clr;

  int tests = 0;
  int fails = 0;

  dac_serial_driver dut (
    .clk_X4(clk), .rst(rst), .enable(enable), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .clr_req(clr_req), .busy(busy), .frame_done(frame_done),
    .CLK_3(CLK_3), .SDI_4(SDI_4), .LD_5(LD_5), .CLR_6(CLR_6)
  );

  dac_serial_driver #(.DATA_W(16), .DIV(8)) dut2 (
    .clk_X4(clk), .rst(rst), .enable(enable), .data_in(d2_data), .data_valid(d2_valid),
    .data_ready(d2_ready), .clr_req(1'b0), .busy(d2_busy), .frame_done(d2_done),
    .CLK_3(d2_clk), .SDI_4(d2_sdi), .LD_5(d2_ld), .CLR_6(d2_clr)
  );

  typedef struct {
    logic [11:0] sample;
    logic [11:0] exp_word;
    int          exp_rises;
    int          exp_ld;
    int          exp_done;
    int          exp_ones;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] pins();
    return {CLK_3, SDI_4, LD_5, CLR_6, busy, frame_done, data_ready};
  endfunction

  function automatic logic [6:0] pins2();
    return {d2_clk, d2_sdi, d2_ld, d2_clr, d2_busy, d2_done, d2_ready};
  endfunction

  // Expected pins for cycle n after the accepting edge, built from the frame timing rules.
  function automatic logic [6:0] frame_model(input int n, input logic [31:0] s, input int w, input int div);
    int   sh  = w * div;
    int   ld0 = sh + LDS + 1;
    int   ld1 = sh + LDS + LDL;
    logic c = 1'b1, d = 1'b0, l = 1'b1, b = 1'b1, dn = 1'b0, r = 1'b0;
    if (n <= sh) begin
      c = ((n - 1) % div) >= (div / 2);
      d = s[w - 1 - (n - 1) / div];
    end
    if (n >= ld0 && n <= ld1) l = 1'b0;
    if (n == ld1 + 1) dn = 1'b1;
    if (n >= ld1 + GP + 1) begin
      b = 1'b0;
      r = 1'b1;
    end
    return {c, d, l, 1'b1, b, dn, r};
  endfunction

  task automatic send(input logic [11:0] s, input bit hold);
    int k = 0;
    @(negedge clk);
    data_in    = s;
    data_valid = 1'b1;
    while (!data_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_send", 32'(data_ready), 32'(1'b1));
    @(posedge clk);
    #1;
    if (!hold) data_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [11:0] s, output int rises, output int ld_first,
                           output int done_at, output logic [11:0] word, output int ones);
    logic prev = 1'b1;
    rises = 0; ld_first = 0; done_at = 0; word = '0; ones = 0;
    for (int n = 1; n <= 12 * 4 + LDS + LDL + GP + 1; n++) begin
      @(negedge clk);
      check($sformatf("frame_%03h_cyc%0d", s, n), 32'(pins()), 32'(frame_model(n, 32'(s), 12, 4)));
      if (CLK_3 && !prev) begin
        rises++;
        word = {word[10:0], SDI_4};
      end
      prev = CLK_3;
      if (!LD_5 && ld_first == 0) ld_first = n;
      if (frame_done) done_at = n;
      if (SDI_4) ones++;
    end
  endtask

  task automatic do_clear(input bit with_valid, input logic [11:0] s);
    int r, lf, da, on;
    logic [11:0] wd;
    @(negedge clk);
    clr_req    = 1'b1;
    data_valid = with_valid;
    data_in    = s;
    #1;
    check("ready_masked_by_clr", 32'(data_ready), 32'(1'b0));
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    for (int n = 1; n <= CLW + 1; n++) begin
      @(negedge clk);
      if (n <= CLW) check($sformatf("clear_cyc%0d", n), 32'(pins()), 32'(7'b1010100));
      else          check($sformatf("clear_exit%0d", n), 32'(pins()), 32'({5'b10110, 1'b0, 1'b1}));
    end
    if (with_valid) begin
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      run_frame(s, r, lf, da, wd, on);
      check("clear_then_sample_word", 32'(wd), 32'(s));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, lf, da, on;
    logic [11:0] wd, s;
    logic prev;

    tbl[0] = '{12'hAAA, 12'hAAA, 12, 51, 53, 24};
    tbl[1] = '{12'h000, 12'h000, 12, 51, 53, 0};
    tbl[2] = '{12'hFFF, 12'hFFF, 12, 51, 53, 48};
    tbl[3] = '{12'h5A5, 12'h5A5, 12, 51, 53, 24};
    tbl[4] = '{12'h801, 12'h801, 12, 51, 53, 8};

    rst = 1'b1; enable = 1'b1; data_valid = 1'b0; clr_req = 1'b0; data_in = '0;
    d2_data = '0; d2_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pins", 32'(pins()), 32'(7'b1011000));
    check("reset_pins_dut2", 32'(pins2()), 32'(7'b1011000));
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(data_ready), 32'(1'b1));

    foreach (tbl[i]) begin
      send(tbl[i].sample, 1'b0);
      run_frame(tbl[i].sample, r, lf, da, wd, on);
      check($sformatf("tbl%0d_word", i), 32'(wd), 32'(tbl[i].exp_word));
      check($sformatf("tbl%0d_rises", i), 32'(r), 32'(tbl[i].exp_rises));
      check($sformatf("tbl%0d_ld_first", i), 32'(lf), 32'(tbl[i].exp_ld));
      check($sformatf("tbl%0d_done", i), 32'(da), 32'(tbl[i].exp_done));
      check($sformatf("tbl%0d_sdi_ones", i), 32'(on), 32'(tbl[i].exp_ones));
    end

    // Back-to-back with valid held: second accept lands on the first ready cycle.
    send(12'h000, 1'b1);
    data_in = 12'hFFF;
    run_frame(12'h000, r, lf, da, wd, on);
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    run_frame(12'hFFF, r, lf, da, wd, on);
    check("b2b_fff_ones", 32'(on), 32'(48));

    do_clear(1'b1, 12'h3C7);

    // enable dropped in cycle 20 of a frame.
    send(12'hF0F, 1'b0);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    lf = 0;
    for (int n = 21; n <= 80; n++) begin
      @(negedge clk);
      check($sformatf("abort_cyc%0d", n), 32'(pins()), 32'(7'b1011000));
      if (!LD_5) lf++;
    end
    check("abort_no_ld", 32'(lf), 32'(0));
    enable = 1'b1;
    #1;
    check("abort_ready_restored", 32'(data_ready), 32'(1'b1));
    send(12'h123, 1'b0);
    run_frame(12'h123, r, lf, da, wd, on);
    check("after_abort_word", 32'(wd), 32'(12'h123));

    // rst asserted mid-frame.
    send(12'hABC, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pins", 32'(pins()), 32'(7'b1011000));
    rst = 1'b0;
    #1;
    check("midrst_ready", 32'(data_ready), 32'(1'b1));

    // 16-bit / DIV=8 instance.
    @(negedge clk);
    d2_data  = 16'h8001;
    d2_valid = 1'b1;
    check("d2_ready", 32'(d2_ready), 32'(1'b1));
    @(posedge clk);
    #1;
    d2_valid = 1'b0;
    r = 0; on = 0; prev = 1'b1;
    for (int n = 1; n <= 16 * 8 + LDS + LDL + GP + 1; n++) begin
      @(negedge clk);
      check($sformatf("d2_cyc%0d", n), 32'(pins2()), 32'(frame_model(n, 32'(16'h8001), 16, 8)));
      if (d2_clk && !prev) r++;
      prev = d2_clk;
      if (d2_sdi) on++;
    end
    check("d2_rises", 32'(r), 32'(16));
    check("d2_sdi_ones", 32'(on), 32'(16));

    // Randomised frames with idle gaps and occasional clears.
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) do_clear(1'b0, 12'h000);
      s = 12'($urandom);
      send(s, 1'b0);
      run_frame(s, r, lf, da, wd, on);
      check($sformatf("rand%0d_word", i), 32'(wd), 32'(s));
    end

`ifdef DAC_AUTO_REPEAT_EN
    do_reset();
    send(12'h5A5, 1'b0);
    for (int k = 0; k < 3; k++) begin
      run_frame(12'h5A5, r, lf, da, wd, on);
      check($sformatf("repeat%0d_word", k), 32'(wd), 32'(12'h5A5));
      @(posedge clk);
    end
`else
    do_reset();
    send(12'h5A5, 1'b0);
    run_frame(12'h5A5, r, lf, da, wd, on);
    lf = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (busy || !CLK_3) lf++;
    end
    check("single_frame_then_idle", 32'(lf), 32'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
